// File: rtl/hack_memory_io.sv
// -----------------------------------------------------------------------------
// hack_memory_io
//
// Data-memory and I/O stage that sits directly behind the Hack CPU. It decodes
// the Hack data address map into three targets:
//   0x0000-0x3FFF  data RAM       (asynchronous read, write on clock edge)
//   0x4000-0x5FFF  screen buffer  (asynchronous CPU read, plus a registered
//                                  read port for a display scanner)
//   0x6000         keyboard       (head of a small keycode FIFO; a CPU write
//                                  of any data pops the head)
//   0x6001-0x7FFF  unmapped       (reads 0x0000, writes dropped)
// addressM[15] is ignored, so the map repeats in the upper half.
//
// Ports
//   clk         in   1  single clock, rising-edge
//   reset_n     in   1  asynchronous active-low reset
//   addressM    in  16  CPU data address
//   outM        in  16  CPU write data
//   writeM      in   1  CPU write strobe
//   inM         out 16  read data for addressM, combinational
//   key_code    in   8  keycode from the keyboard decoder
//   key_valid   in   1  key_code valid
//   key_ready   out  1  FIFO can accept a code (not full)
//   scr_addr    in  13  display scanner word address
//   scr_data    out 16  screen word at scr_addr, one-cycle latency
//   addr_fault  out  1  sticky fault flag
//
// Build option
//   HACK_MEM_FAULT_EN : when defined, addr_fault sets on any CPU write to an
//                       address above 0x6000 and holds until reset. When not
//                       defined, addr_fault is tied low and no logic is built.
//
// RAM and screen contents are never reset; only the keyboard FIFO state, the
// scanner output register and the fault flag are.
// -----------------------------------------------------------------------------
module hack_memory_io #(
  parameter int RAM_WORDS = 16384,
  parameter int SCR_WORDS = 8192,
  parameter int KEY_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] inM,
  input  logic [7:0]  key_code,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [12:0] scr_addr,
  output logic [15:0] scr_data,
  output logic        addr_fault
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int SCR_AW = $clog2(SCR_WORDS);
  localparam int KEY_PW = $clog2(KEY_DEPTH);
  localparam int KEY_CW = KEY_PW + 1;

  localparam logic [KEY_CW-1:0] KEY_FULL = KEY_CW'(KEY_DEPTH);
  localparam logic [14:0]       KBD_ADDR = 15'h6000;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [14:0] cpu_addr;
  logic        sel_ram;
  logic        sel_scr;
  logic        sel_kbd;
  logic        unused_addr_msb;

  assign cpu_addr        = addressM[14:0];
  assign unused_addr_msb = addressM[15];

  // RAM is the lower half of the 15-bit space, screen the next 8K words.
  assign sel_ram = ~cpu_addr[14];
  assign sel_scr = (cpu_addr[14:13] == 2'b10);
  assign sel_kbd = (cpu_addr == KBD_ADDR);

  logic [RAM_AW-1:0] ram_idx;
  logic [SCR_AW-1:0] scr_idx;
  logic [SCR_AW-1:0] scan_idx;

  assign ram_idx  = cpu_addr[RAM_AW-1:0];
  assign scr_idx  = cpu_addr[SCR_AW-1:0];
  assign scan_idx = scr_addr[SCR_AW-1:0];

  logic ram_we;
  logic scr_we;

  assign ram_we = writeM & sel_ram;
  assign scr_we = writeM & sel_scr;

  // ---------------------------------------------------------------------------
  // Data RAM and screen buffer (contents not reset)
  // ---------------------------------------------------------------------------
  logic [15:0] ram_mem [RAM_WORDS];
  logic [15:0] scr_mem [SCR_WORDS];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_mem[ram_idx] <= outM;
    end
    if (scr_we) begin
      scr_mem[scr_idx] <= outM;
    end
  end

  // ---------------------------------------------------------------------------
  // Keyboard FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]        key_mem_q [KEY_DEPTH];
  logic [7:0]        key_mem_d [KEY_DEPTH];
  logic [KEY_PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [KEY_PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [KEY_CW-1:0] count_q, count_d;

  logic key_full;
  logic key_empty;
  logic key_push;
  logic key_pop;

  assign key_full  = (count_q == KEY_FULL);
  assign key_empty = (count_q == '0);
  assign key_ready = ~key_full;

  // Push is gated by the registered full flag, so a pop on a full FIFO does
  // not open a slot until the following cycle.
  assign key_push = key_valid & ~key_full;
  // Any CPU write to the keyboard address is a pop request; ignored if empty.
  assign key_pop  = writeM & sel_kbd & ~key_empty;

  always_comb begin
    key_mem_d = key_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;

    if (key_push) begin
      key_mem_d[wr_ptr_q] = key_code;
      wr_ptr_d            = wr_ptr_q + KEY_PW'(1);
    end
    if (key_pop) begin
      rd_ptr_d = rd_ptr_q + KEY_PW'(1);
    end

    // Simultaneous push and pop leaves the occupancy unchanged.
    if (key_push && !key_pop) begin
      count_d = count_q + KEY_CW'(1);
    end else if (key_pop && !key_push) begin
      count_d = count_q - KEY_CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < KEY_DEPTH; i++) begin
        key_mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      key_mem_q <= key_mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Display scanner read port
  // ---------------------------------------------------------------------------
  // The array write above and this register capture both use the pre-edge
  // array contents, so a same-edge CPU write yields the old word here.
  logic [15:0] scr_data_q, scr_data_d;

  assign scr_data_d = scr_mem[scan_idx];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scr_data_q <= '0;
    end else begin
      scr_data_q <= scr_data_d;
    end
  end

  assign scr_data = scr_data_q;

  // ---------------------------------------------------------------------------
  // CPU read mux (combinational, same-cycle)
  // ---------------------------------------------------------------------------
  always_comb begin
    inM = '0;
    if (sel_ram) begin
      inM = ram_mem[ram_idx];
    end else if (sel_scr) begin
      inM = scr_mem[scr_idx];
    end else if (sel_kbd && !key_empty) begin
      inM = {8'h00, key_mem_q[rd_ptr_q]};
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky address fault
  // ---------------------------------------------------------------------------
`ifdef HACK_MEM_FAULT_EN
  logic fault_q, fault_d;

  // Anything above the keyboard register is unmapped; writing there is a
  // software bug worth latching for the debugger.
  assign fault_d = fault_q | (writeM & (cpu_addr > KBD_ADDR));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign addr_fault = fault_q;
`else
  assign addr_fault = 1'b0;
`endif

endmodule

// File: tb/tb_hack_memory_io.sv
`timescale 1ns/100ps
module tb_hack_memory_io;

  localparam int KD = 4;
`ifdef HACK_MEM_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] inM;
  logic [7:0]  key_code;
  logic        key_valid;
  logic        key_ready;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
  logic        addr_fault;

  int errors = 0;
  int checks = 0;

  // Behavioural model: sparse memories, a queue for the keyboard buffer.
  logic [15:0] ram_m [int];
  logic [15:0] scr_m [int];
  logic [7:0]  kq [$];
  bit          fault_m;
  logic [15:0] scr_exp;
  bit          scr_known;

  hack_memory_io #(
    .RAM_WORDS(16384),
    .SCR_WORDS(8192),
    .KEY_DEPTH(KD)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .addressM  (addressM),
    .outM      (outM),
    .writeM    (writeM),
    .inM       (inM),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .scr_addr  (scr_addr),
    .scr_data  (scr_data),
    .addr_fault(addr_fault)
  );

  always #10 clk = ~clk;

  // Advance the model by one clock edge using the current inputs, then clock.
  task automatic apply_edge();
    int  a;
    bit  was_full;
    a        = int'(addressM[14:0]);
    was_full = (kq.size() == KD);
    scr_known = scr_m.exists(int'(scr_addr));
    if (scr_known) scr_exp = scr_m[int'(scr_addr)];
    if (writeM) begin
      if (a < 'h4000)       ram_m[a] = outM;
      else if (a < 'h6000)  scr_m[a - 'h4000] = outM;
      else if (a == 'h6000) begin
        if (kq.size() > 0) kq.delete(0);
      end else if (FAULT_EN) fault_m = 1'b1;
    end
    if (key_valid && !was_full) kq.push_back(key_code);
    @(posedge clk);
    #1;
  endtask

  function automatic bit exp_inm(input logic [15:0] addr, output logic [15:0] v);
    int a;
    a = int'(addr[14:0]);
    v = 16'h0000;
    if (a < 'h4000) begin
      if (!ram_m.exists(a)) return 1'b0;
      v = ram_m[a];
    end else if (a < 'h6000) begin
      if (!scr_m.exists(a - 'h4000)) return 1'b0;
      v = scr_m[a - 'h4000];
    end else if (a == 'h6000) begin
      if (kq.size() > 0) v = {8'h00, kq[0]};
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    kq.delete();
    fault_m   = 1'b0;
    scr_known = 1'b1;
    scr_exp   = 16'h0000;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; addressM = 16'h6000; outM = 16'h0; writeM = 1'b0;
    key_code = 8'h0; key_valid = 1'b0; scr_addr = 13'h0;
    model_reset();
    #2;
    checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL reset_key_ready: got %b expected 1", key_ready); end
    checks++; if (scr_data !== 16'h0000) begin errors++; $display("FAIL reset_scr_data: got %h expected 0000", scr_data); end
    checks++; if (addr_fault !== 1'b0) begin errors++; $display("FAIL reset_addr_fault: got %b expected 0", addr_fault); end
    checks++; if (inM !== 16'h0000) begin errors++; $display("FAIL reset_kbd_read: got %h expected 0000", inM); end
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_ram_rw();
    addressM = 16'h0010; outM = 16'h1234; writeM = 1'b1;
    apply_edge();
    writeM = 1'b0; #1;
    checks++; if (inM !== 16'h1234) begin errors++; $display("FAIL ram_read: got %h expected 1234", inM); end
    addressM = 16'h8010; #1;
    checks++; if (inM !== 16'h1234) begin errors++; $display("FAIL ram_read_bit15: got %h expected 1234", inM); end
    addressM = 16'h6000; #1;
    checks++; if (inM !== 16'h0000) begin errors++; $display("FAIL kbd_empty_read: got %h expected 0000", inM); end
    checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL idle_key_ready: got %b expected 1", key_ready); end
  endtask

  task automatic test_screen_port();
    scr_addr = 13'h0000;
    addressM = 16'h4005; outM = 16'h00AA; writeM = 1'b1; apply_edge();
    addressM = 16'h0005; outM = 16'h5555; apply_edge();
    scr_addr = 13'h0005;
    addressM = 16'h4005; outM = 16'hFFFF; apply_edge();
    checks++; if (scr_data !== 16'h00AA) begin errors++; $display("FAIL scr_same_edge_old: got %h expected 00aa", scr_data); end
    writeM = 1'b0; apply_edge();
    checks++; if (scr_data !== 16'hFFFF) begin errors++; $display("FAIL scr_new_word: got %h expected ffff", scr_data); end
    addressM = 16'h0005; #1;
    checks++; if (inM !== 16'h5555) begin errors++; $display("FAIL ram_not_aliased: got %h expected 5555", inM); end
    addressM = 16'h4005; #1;
    checks++; if (inM !== 16'hFFFF) begin errors++; $display("FAIL scr_cpu_read: got %h expected ffff", inM); end
  endtask

  task automatic test_kbd_basic();
    addressM = 16'h6000; writeM = 1'b0;
    key_valid = 1'b1; key_code = 8'h41; apply_edge();
    key_code = 8'h42; apply_edge();
    key_valid = 1'b0; #1;
    checks++; if (inM !== 16'h0041) begin errors++; $display("FAIL kbd_head_41: got %h expected 0041", inM); end
    writeM = 1'b1; outM = 16'($urandom); apply_edge();
    writeM = 1'b0; #1;
    checks++; if (inM !== 16'h0042) begin errors++; $display("FAIL kbd_head_42: got %h expected 0042", inM); end
    writeM = 1'b1; apply_edge();
    writeM = 1'b0; #1;
    checks++; if (inM !== 16'h0000) begin errors++; $display("FAIL kbd_drained: got %h expected 0000", inM); end
    writeM = 1'b1; apply_edge();
    writeM = 1'b0; #1;
    checks++; if (inM !== 16'h0000) begin errors++; $display("FAIL kbd_pop_empty: got %h expected 0000", inM); end
    checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL kbd_pop_empty_ready: got %b expected 1", key_ready); end
    key_valid = 1'b1; key_code = 8'h43; apply_edge();
    key_valid = 1'b0; #1;
    checks++; if (inM !== 16'h0043) begin errors++; $display("FAIL kbd_after_empty_pop: got %h expected 0043", inM); end
    writeM = 1'b1; apply_edge();
    writeM = 1'b0;
  endtask

  task automatic test_kbd_full();
    logic [7:0] want [4];
    want[0] = 8'h11; want[1] = 8'h12; want[2] = 8'h13; want[3] = 8'h99;
    addressM = 16'h6000; writeM = 1'b0;
    for (int i = 0; i < 4; i++) begin
      key_valid = 1'b1; key_code = 8'(8'h10 + i); apply_edge();
    end
    key_valid = 1'b0; #1;
    checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL full_key_ready: got %b expected 0", key_ready); end
    checks++; if (inM !== 16'h0010) begin errors++; $display("FAIL full_head: got %h expected 0010", inM); end
    // Pop and attempted push on the same edge while full: push refused.
    key_valid = 1'b1; key_code = 8'h99; writeM = 1'b1; apply_edge();
    checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL full_pop_ready: got %b expected 1", key_ready); end
    checks++; if (inM !== 16'h0011) begin errors++; $display("FAIL full_pop_head: got %h expected 0011", inM); end
    writeM = 1'b0; apply_edge();
    key_valid = 1'b0; #1;
    checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL refill_key_ready: got %b expected 0", key_ready); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (inM !== {8'h00, want[i]}) begin errors++; $display("FAIL wrap_order[%0d]: got %h expected %h", i, inM, {8'h00, want[i]}); end
      writeM = 1'b1; apply_edge();
      writeM = 1'b0; #1;
    end
    checks++; if (inM !== 16'h0000) begin errors++; $display("FAIL wrap_drained: got %h expected 0000", inM); end
  endtask

  task automatic test_fault();
    writeM = 1'b1;
    addressM = 16'h3010; outM = 16'h1111; apply_edge();
    addressM = 16'h5010; outM = 16'h2222; apply_edge();
    addressM = 16'h7010; outM = 16'hDEAD; apply_edge();
    writeM = 1'b0; #1;
    checks++; if (addr_fault !== FAULT_EN) begin errors++; $display("FAIL fault_set: got %b expected %b", addr_fault, FAULT_EN); end
    checks++; if (inM !== 16'h0000) begin errors++; $display("FAIL unmapped_read: got %h expected 0000", inM); end
    apply_edge(); apply_edge();
    checks++; if (addr_fault !== FAULT_EN) begin errors++; $display("FAIL fault_sticky: got %b expected %b", addr_fault, FAULT_EN); end
    addressM = 16'h3010; #1;
    checks++; if (inM !== 16'h1111) begin errors++; $display("FAIL fault_ram_kept: got %h expected 1111", inM); end
    addressM = 16'h5010; #1;
    checks++; if (inM !== 16'h2222) begin errors++; $display("FAIL fault_scr_kept: got %h expected 2222", inM); end
  endtask

  task automatic test_async_reset();
    addressM = 16'h0020; outM = 16'hBEEF; writeM = 1'b1;
    key_valid = 1'b1; key_code = 8'h51; apply_edge();
    writeM = 1'b0; key_code = 8'h52; apply_edge();
    key_code = 8'h53; apply_edge();
    key_valid = 1'b0; addressM = 16'h6000; #1;
    checks++; if (inM !== 16'h0051) begin errors++; $display("FAIL prereset_head: got %h expected 0051", inM); end
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    checks++; if (inM !== 16'h0000) begin errors++; $display("FAIL async_reset_fifo: got %h expected 0000", inM); end
    checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL async_reset_ready: got %b expected 1", key_ready); end
    checks++; if (addr_fault !== 1'b0) begin errors++; $display("FAIL async_reset_fault: got %b expected 0", addr_fault); end
    checks++; if (scr_data !== 16'h0000) begin errors++; $display("FAIL async_reset_scr: got %h expected 0000", scr_data); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    addressM = 16'h0020; #1;
    checks++; if (inM !== 16'hBEEF) begin errors++; $display("FAIL ram_survives_reset: got %h expected beef", inM); end
    addressM = 16'h0010; #1;
    checks++; if (inM !== 16'h1234) begin errors++; $display("FAIL ram_survives_reset2: got %h expected 1234", inM); end
  endtask

  task automatic test_random();
    logic [15:0] v;
    int          r;
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4)       addressM = 16'($urandom_range(0, 15));
      else if (r < 7)  addressM = 16'('h4000 + $urandom_range(0, 15));
      else if (r < 9)  addressM = 16'h6000;
      else             addressM = 16'($urandom_range('h6001, 'h7FFF));
      addressM[15] = 1'($urandom);
      outM      = 16'($urandom);
      writeM    = ($urandom_range(0, 9) < 4);
      key_valid = 1'($urandom);
      key_code  = 8'($urandom);
      scr_addr  = 13'($urandom_range(0, 15));
      #1;
      if (exp_inm(addressM, v)) begin
        checks++; if (inM !== v) begin errors++; $display("FAIL rand_inM[%0d] addr %h: got %h expected %h", n, addressM, inM, v); end
      end
      apply_edge();
      checks++; if (key_ready !== (kq.size() != KD)) begin errors++; $display("FAIL rand_key_ready[%0d]: got %b expected %b", n, key_ready, (kq.size() != KD)); end
      checks++; if (addr_fault !== fault_m) begin errors++; $display("FAIL rand_fault[%0d]: got %b expected %b", n, addr_fault, fault_m); end
      if (scr_known) begin
        checks++; if (scr_data !== scr_exp) begin errors++; $display("FAIL rand_scr_data[%0d]: got %h expected %h", n, scr_data, scr_exp); end
      end
    end
    writeM = 1'b0; key_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ram_rw();
    test_screen_port();
    test_kbd_basic();
    test_kbd_full();
    test_fault();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
